// File: rtl/div_unit32.sv
// div_unit32: 32-bit restoring divider producing one quotient bit per cycle, with valid/ready on both sides.
// Define DIV_UNIT32_SIGNED_EN to add two's-complement division selected by is_signed.
module div_unit32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
    // in_ready is 1 only in IDLE, out_valid only in DONE; DONE holds its outputs until out_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [5:0]  step_cnt;
    logic [31:0] rem_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;

    // 33-bit a - b with 4-bit group generate/propagate borrow lookahead; returns {borrow_out, diff}.
    function automatic logic [33:0] sub33(input logic [32:0] a, input logic [32:0] b);
        logic [32:0] g;
        logic [32:0] p;
        logic [32:0] bw;
        logic [8:0]  gb;
        logic [3:0]  gg;
        logic [3:0]  pp;
        logic        c;
        g     = ~a & b;
        p     = ~(a ^ b);
        bw    = '0;
        gb    = '0;
        for (int k = 0; k < 8; k++) begin
            gg            = g[4*k +: 4];
            pp            = p[4*k +: 4];
            c             = gb[k];
            bw[4*k]       = c;
            bw[4*k+1]     = gg[0] | (pp[0] & c);
            bw[4*k+2]     = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
            bw[4*k+3]     = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                          | (pp[2] & pp[1] & pp[0] & c);
            gb[k+1]       = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                          | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c);
        end
        bw[32] = gb[8];
        return {g[32] | (p[32] & gb[8]), a ^ b ^ bw};
    endfunction

    logic [32:0] shifted;
    logic [33:0] sub_res;
    logic        qbit;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        is_zero;
    logic        is_ovf;
    logic        unused_trial_msb;

    // The remainder stays below the divisor, so a set shifted[32] always means no borrow.
    assign shifted          = {rem_q, dvd_q[31]};
    assign sub_res          = sub33(shifted, {1'b0, dsr_q});
    assign qbit             = ~sub_res[33];
    assign rem_next         = qbit ? sub_res[31:0] : shifted[31:0];
    assign quo_next         = {dvd_q[30:0], qbit};
    assign unused_trial_msb = sub_res[32];
    assign is_zero          = (divisor == 32'd0);

`ifdef DIV_UNIT32_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic q_neg;
    logic r_neg;

    assign a_neg  = is_signed & dividend[31];
    assign b_neg  = is_signed & divisor[31];
    assign a_mag  = a_neg ? (32'd0 - dividend) : dividend;
    assign b_mag  = b_neg ? (32'd0 - divisor) : divisor;
    assign is_ovf = is_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
    assign q_fin  = q_neg ? (32'd0 - quo_next) : quo_next;
    assign r_fin  = r_neg ? (32'd0 - rem_next) : rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag            = dividend;
    assign b_mag            = divisor;
    assign is_ovf           = 1'b0;
    assign q_fin            = quo_next;
    assign r_fin            = rem_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_cnt  <= 6'd0;
            rem_q     <= 32'd0;
            dvd_q     <= 32'd0;
            dsr_q     <= 32'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_zero) begin
                            quotient  <= 32'hFFFF_FFFF;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (is_ovf) begin
                            quotient  <= 32'h8000_0000;
                            remainder <= 32'd0;
                            div_zero  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem_q    <= 32'd0;
                            dvd_q    <= a_mag;
                            dsr_q    <= b_mag;
                            step_cnt <= 6'd0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q    <= rem_next;
                    dvd_q    <= quo_next;
                    step_cnt <= step_cnt + 6'd1;
                    if (step_cnt == 6'd31) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/div_unit32.md
DIV_UNIT32 -- requirements
Module: div_unit32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port in_valid, input, 1 bit: operands valid.
REQ-005 Port in_ready, output, 1 bit: block can accept operands.
REQ-006 Port dividend, input, 32 bits: numerator, sampled on the input handshake.
REQ-007 Port divisor, input, 32 bits: denominator, sampled on the input handshake.
REQ-008 Port is_signed, input, 1 bit: selects two's-complement operation, sampled on the input handshake.
REQ-009 Port out_valid, output, 1 bit: result valid.
REQ-010 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 Port quotient, output, 32 bits: result quotient.
REQ-012 Port remainder, output, 32 bits: result remainder.
REQ-013 Port div_zero, output, 1 bit: divisor was zero.

Function
REQ-014 An input handshake SHALL occur when in_valid and in_ready are both 1 on a clk edge; an output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-015 The FSM SHALL have the states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 IDLE SHALL go to CALC on an input handshake, or directly to DONE when the divisor is 0 or the operation is signed overflow.
REQ-017 CALC SHALL perform one restoring step per cycle, 32 steps in total, driven by a 6-bit step counter; the trial subtraction SHALL be 33 bits wide and SHALL use group generate/propagate borrow logic in 4-bit groups, not a ripple chain.
REQ-018 Each step SHALL shift the remainder left with the next dividend bit (MSB first) and compute trial = rem - divisor; when there is no borrow, rem SHALL take trial and the quotient bit SHALL be 1, otherwise the quotient bit SHALL be 0.
REQ-019 CALC SHALL go to DONE after step 32; the normal latency from input handshake to out_valid SHALL be 33 cycles.
REQ-020 The special cases SHALL have a latency of 1 cycle.
REQ-021 DONE SHALL hold quotient, remainder and div_zero stable while out_ready is 0, and SHALL go to IDLE on an output handshake.
REQ-022 A divisor of 0 SHALL produce quotient 0xFFFFFFFF, remainder = dividend and div_zero = 1.
REQ-023 Unsigned results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
REQ-024 in_valid SHALL be ignored outside IDLE, and operand changes during CALC SHALL have no effect.
REQ-025 quotient and remainder SHALL be registered outputs.

Reset
REQ-026 Asserting rst_n low SHALL force IDLE at any time, including mid-CALC or DONE, discarding any operation in flight.
REQ-027 Reset values: in_ready = 1 once rst_n is high; out_valid = 0; quotient = 0; remainder = 0; div_zero = 0; step counter = 0.
REQ-028 The first input handshake SHALL be accepted on the first clk edge after rst_n is deasserted.

Configuration
REQ-029 The macro DIV_UNIT32_SIGNED_EN SHALL control signed support.
REQ-030 With DIV_UNIT32_SIGNED_EN defined and is_signed = 1, operands SHALL be converted to magnitudes before CALC, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-031 With DIV_UNIT32_SIGNED_EN defined, 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 with 1-cycle latency; a signed divide by zero SHALL return remainder = the original dividend.
REQ-032 Without DIV_UNIT32_SIGNED_EN, is_signed SHALL be ignored, the overflow detection and sign logic SHALL be absent, and all operations SHALL be unsigned.

Verification
REQ-033 Unsigned 100 / 7 with out_ready = 1 -> out_valid exactly 33 cycles after the handshake; quotient 14, remainder 2, div_zero 0.
REQ-034 0x12345678 / 0 -> out_valid after 1 cycle; quotient 0xFFFFFFFF, remainder 0x12345678, div_zero 1.
REQ-035 Signed (macro on) -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 0x80000000 / -1 -> quotient 0x80000000, remainder 0 after 1 cycle.
REQ-036 0xFFFFFFFF / 1 with out_ready held 0 for 10 cycles -> outputs remain stable and in_ready stays 0; the result is released on the cycle out_ready rises.
REQ-037 rst_n pulsed low at CALC step 15 -> out_valid 0 and in_ready 1 immediately; the next operation 9 / 3 -> quotient 3, remainder 0.
REQ-038 1000 random unsigned pairs checked against the REQ-023 identity -> zero mismatches; in_valid held high in CALC -> no extra handshakes.
